if_id_stage: RTL and testbench

- Fetch-to-decode pipeline stage of the 32-bit CPU.
- Accepts fetched instructions and their PC over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Presents the registered instruction split into fields. out_imm (15 bits) feeds the sign extender directly.
- Supports a decode-side flush for branches and jumps, and keeps a saturating stall counter.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/skid_buf2.sv | 76 +++++++
 rtl/if_id_stage.sv | 68 ++++++
 tb/tb_if_id_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, instruction field positions and the field splitter
// Contents:
//   DATA_W, IMM_W, OPC_W, REG_AW  - datapath and field widths
//   OPC_MSB, RD_LSB, RS_LSB,
//   RT_LSB, IMM_MSB               - instruction field bit positions
//   instr_fields_t                - decoded field bundle
//   split_instr()                 - slices a raw instruction into instr_fields_t
package cpu_pkg;
    localparam int DATA_W  = 32;
    localparam int IMM_W   = 15;
    localparam int OPC_W   = 7;
    localparam int REG_AW  = 5;
    localparam int OPC_MSB = 31;
    localparam int RD_LSB  = 20;
    localparam int RS_LSB  = 15;
    localparam int RT_LSB  = 10;
    localparam int IMM_MSB = 14;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [IMM_W-1:0]  imm;
    } instr_fields_t;

    // rt and imm overlap on purpose: rt is only meaningful for R-type words
    function automatic instr_fields_t split_instr(input logic [DATA_W-1:0] instr);
        instr_fields_t f;
        f.opcode = instr[OPC_MSB -: OPC_W];
        f.rd     = instr[RD_LSB +: REG_AW];
        f.rs     = instr[RS_LSB +: REG_AW];
        f.rt     = instr[RT_LSB +: REG_AW];
        f.imm    = instr[IMM_MSB:0];
        return f;
    endfunction
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: generic 2-entry valid/ready skid buffer with flush
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   flush                 - drop both entries; a same-cycle input is dropped,
//                           a same-cycle output transfer still completes
//   in_valid/in_ready     - upstream handshake; in_ready is registered
//   in_data               - upstream payload
//   out_valid/out_ready   - downstream handshake, driven from the main entry
//   out_data              - main-entry payload, held while stalled or empty
module skid_buf2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         ready_q;
    logic         in_xfer, out_xfer;

    assign in_xfer   = in_valid && ready_q;
    assign out_xfer  = main_valid_q && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q && out_xfer) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (!skid_valid_q && in_xfer && (!main_valid_q || out_xfer)) begin
            main_d       = in_data;
            main_valid_d = 1'b1;
        end else if (!skid_valid_q && in_xfer) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
        end
        // flush keeps the data registers untouched so a dropped input never lands anywhere
        if (flush) begin
            main_d       = main_q;
            skid_d       = skid_q;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch-to-decode stage with 2-entry skid buffer, field split and stall counter
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - fetch handshake (in_ready registered)
//   in_instr, in_pc               - fetched instruction and its PC
//   flush                         - discard buffered instructions (branch/jump)
//   out_valid/out_ready           - decode handshake
//   out_instr, out_pc             - registered instruction and PC
//   out_opcode/rd/rs/rt/imm       - slices of out_instr; imm is unextended
//   stall_cnt                     - saturating count of out_valid & !out_ready edges
module if_id_stage import cpu_pkg::*; #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_instr,
    input  logic [DATA_W-1:0]      in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_instr,
    output logic [DATA_W-1:0]      out_pc,
    output logic [OPC_W-1:0]       out_opcode,
    output logic [REG_AW-1:0]      out_rd,
    output logic [REG_AW-1:0]      out_rs,
    output logic [REG_AW-1:0]      out_rt,
    output logic [IMM_W-1:0]       out_imm,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    logic [2*DATA_W-1:0]    payload;
    instr_fields_t          fields;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    skid_buf2 #(
        .W(2*DATA_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({in_pc, in_instr}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (payload)
    );

    assign out_pc     = payload[2*DATA_W-1:DATA_W];
    assign out_instr  = payload[DATA_W-1:0];
    assign fields     = split_instr(out_instr);
    assign out_opcode = fields.opcode;
    assign out_rd     = fields.rd;
    assign out_rs     = fields.rs;
    assign out_rt     = fields.rt;
    assign out_imm    = fields.imm;
    assign stall_cnt  = stall_q;

    always_comb begin
        stall_d = (out_valid && !out_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: table-driven, scoreboarded self-checking bench for if_id_stage
module tb_if_id_stage;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [14:0] imm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs, out_rt;
    logic [14:0] out_imm;
    logic [15:0] stall_cnt;

    vec_t tab [6];
    vec_t sb [$];
    int   cur = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    if_id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx);
        in_valid = 1'b1;
        in_instr = tab[idx].instr;
        in_pc    = tab[idx].pc;
        cur      = idx;
    endtask

    // scoreboard: pop on output transfer, then apply flush, then push accepted input
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {32'h0, out_pc}, 64'hDEAD);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                    check("out_fields", {out_opcode, out_rd, out_rs, out_rt, out_imm},
                          {e.opc, e.rd, e.rs, e.rt, e.imm});
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(tab[cur]);
        end
    end

    initial begin
        tab[0] = '{32'hFE8C7FFF, 32'h100, 7'h7F, 5'h08, 5'h18, 5'h1F, 15'h7FFF};
        tab[1] = '{32'h00000000, 32'h104, 7'h00, 5'h00, 5'h00, 5'h00, 15'h0000};
        tab[2] = '{32'hFFFFFFFF, 32'h108, 7'h7F, 5'h1F, 5'h1F, 5'h1F, 15'h7FFF};
        tab[3] = '{32'h02108421, 32'h10C, 7'h01, 5'h01, 5'h01, 5'h01, 15'h0421};
        tab[4] = '{32'h80004000, 32'h110, 7'h40, 5'h00, 5'h00, 5'h10, 15'h4000};
        tab[5] = '{32'h12345678, 32'hBAD0, 7'h09, 5'h03, 5'h08, 5'h15, 15'h5678};

        // reset held 2 cycles with input offered, which must be ignored
        drive(5);
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall", stall_cnt, 0);
        check("rst_fields", {out_instr, out_pc}, 0);
        check("rst_split", {out_opcode, out_rd, out_rs, out_rt, out_imm}, 0);
        tick();
        check("idle_out_valid", out_valid, 0);

        // streaming at one per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(i);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", out_valid, 0);
        check("stream_stall", stall_cnt, 0);

        // backpressure: A held, B in skid, C held by source
        out_ready = 1'b0;
        drive(0);
        tick();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_instr", out_instr, tab[0].instr);
        drive(1);
        tick();
        check("bp_ready_drop", in_ready, 0);
        drive(2);
        tick();
        check("bp_a_hold", {out_instr, out_pc}, {tab[0].instr, tab[0].pc});
        check("bp_ready_low", in_ready, 0);
        tick();
        tick();
        check("bp_stall", stall_cnt, 4);
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", out_valid, 1);
        tick();
        in_valid = 1'b0;
        check("bp_c_valid", out_valid, 1);
        tick();
        check("bp_drained", out_valid, 0);
        check("bp_stall_kept", stall_cnt, 4);

        // flush with both entries full and an input offered
        out_ready = 1'b0;
        drive(3);
        tick();
        drive(4);
        tick();
        check("fl_full", in_ready, 0);
        drive(5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_stall_kept", stall_cnt, 6);
        tick();
        check("fl_stays_empty", out_valid, 0);

        // flush while an input transfer is possible: the input is dropped
        drive(0);
        tick();
        drive(5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_drop_valid", out_valid, 0);
        check("fl_drop_ready", in_ready, 1);
        check("fl_drop_stall", stall_cnt, 7);
        tick();
        check("fl_drop_empty", out_valid, 0);

        // flush coinciding with an output transfer, then flush on empty
        out_ready = 1'b1;
        drive(1);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_xfer_valid", out_valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_empty_valid", out_valid, 0);
        check("fl_empty_ready", in_ready, 1);
        drive(2);
        tick();
        in_valid = 1'b0;
        check("fl_after_valid", out_valid, 1);
        check("fl_after_instr", out_instr, tab[2].instr);
        tick();
        check("fl_after_drained", out_valid, 0);

        // reset (with flush) mid-stream while stalled
        out_ready = 1'b0;
        drive(3);
        tick();
        drive(4);
        tick();
        drive(5);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_ready", in_ready, 1);
        check("mrst_stall", stall_cnt, 0);
        check("mrst_data", {out_instr, out_pc}, 0);
        out_ready = 1'b1;
        drive(3);
        tick();
        in_valid = 1'b0;
        check("mrst_next_valid", out_valid, 1);
        check("mrst_next_opc", out_opcode, tab[3].opc);
        tick();
        check("mrst_drained", out_valid, 0);

        // stall counter saturation
        out_ready = 1'b0;
        drive(4);
        tick();
        in_valid = 1'b0;
        repeat (70000) tick();
        check("sat_stall", stall_cnt, 16'hFFFF);
        check("sat_held", out_instr, tab[4].instr);
        out_ready = 1'b1;
        tick();
        tick();
        check("sat_drained", out_valid, 0);
        check("sat_no_clear", stall_cnt, 16'hFFFF);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
